// File: rtl/pixel_filter_pipe.sv
// Two-stage pixel filter: S1 registers the pixel with its mode/coefficient,
// S2 registers the filtered {alpha,R,G,B} word presented on result.
module pixel_filter_pipe #(
  parameter int              CH_W  = 8,
  parameter logic [CH_W-1:0] ALPHA = {CH_W{1'b1}}
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [4*CH_W-1:0] in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        filterMode,
  input  logic [CH_W-1:0]   brightnessCoeff,
  output logic [4*CH_W-1:0] result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  // Handshake: a beat transfers on a rising edge where valid and ready are
  // both 1; valid/data never change while valid=1 and ready=0.

  logic              s1_v;
  logic [4*CH_W-1:0] s1_pix;
  logic [1:0]        s1_mode;
  logic [CH_W-1:0]   s1_coeff;
  logic              s2_v;
  logic [4*CH_W-1:0] s2_res;

  logic              s1_adv;
  logic              s2_adv;
  logic [4*CH_W-1:0] calc;

  logic [CH_W-1:0]   c0, c1, c2, c3;
  logic [CH_W:0]     g_sum;
  logic [CH_W+1:0]   y_sum;

  function automatic logic [CH_W-1:0] sat_add(input logic [CH_W-1:0] a,
                                              input logic [CH_W-1:0] b);
    logic [CH_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CH_W] ? {CH_W{1'b1}} : s[CH_W-1:0];
  endfunction

  function automatic logic [CH_W-1:0] sat_sub(input logic [CH_W-1:0] a,
                                              input logic [CH_W-1:0] b);
    return (a >= b) ? (a - b) : {CH_W{1'b0}};
  endfunction

  assign s2_adv    = !s2_v || out_ready;
  assign s1_adv    = !s1_v || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_v;
  assign result    = s2_res;
  assign busy      = s1_v || s2_v;

  assign c0 = s1_pix[CH_W-1:0];
  assign c1 = s1_pix[2*CH_W-1:CH_W];
  assign c2 = s1_pix[3*CH_W-1:2*CH_W];
  assign c3 = s1_pix[4*CH_W-1:3*CH_W];

  always_comb begin
    calc  = '0;
    g_sum = {1'b0, c2} + {1'b0, c1};
    // Luma weights 1:2:1; the doubled G needs the extra top bit.
    y_sum = {2'b00, c2} + {1'b0, c1, 1'b0} + {2'b00, c0};
    case (s1_mode)
      2'b00:   calc = {ALPHA, c3, g_sum[CH_W:1], c0};
      2'b01:   calc = {ALPHA, sat_add(c2, s1_coeff), sat_add(c1, s1_coeff),
                       sat_add(c0, s1_coeff)};
      2'b10:   calc = {ALPHA, sat_sub(c2, s1_coeff), sat_sub(c1, s1_coeff),
                       sat_sub(c0, s1_coeff)};
      default: calc = {ALPHA, y_sum[CH_W+1:2], y_sum[CH_W+1:2], y_sum[CH_W+1:2]};
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s1_v     <= 1'b0;
      s1_pix   <= '0;
      s1_mode  <= '0;
      s1_coeff <= '0;
      s2_v     <= 1'b0;
      s2_res   <= '0;
    end else begin
      if (s1_adv) begin
        s1_v <= in_valid;
        if (in_valid) begin
          s1_pix   <= in;
          s1_mode  <= filterMode;
          s1_coeff <= brightnessCoeff;
        end
      end
      if (s2_adv) begin
        s2_v <= s1_v;
        if (s1_v) s2_res <= calc;
      end
    end
  end

endmodule

// File: tb/tb_pixel_filter_pipe.sv
// Directed bench for pixel_filter_pipe: per-mode vectors, back-to-back with a
// mode switch, output stall with backpressure, and mid-stream reset.
module tb_pixel_filter_pipe;

  localparam int CH_W = 8;

  logic              clk;
  logic              n_rst;
  logic [4*CH_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        filter_mode;
  logic [CH_W-1:0]   coeff;
  logic [4*CH_W-1:0] result;
  logic              out_valid;
  logic              out_ready;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [4*CH_W-1:0] exp_q[$];

  pixel_filter_pipe #(.CH_W(CH_W)) dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .in              (in_data),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .filterMode      (filter_mode),
    .brightnessCoeff (coeff),
    .result          (result),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    n_rst = 1'b0; in_valid = 1'b0; in_data = '0; filter_mode = '0;
    coeff = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || result !== 32'h0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: out_valid=%b busy=%b result=%h in_ready=%b, want 0 0 00000000 1",
               out_valid, busy, result, in_ready);
    end
    n_rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_reset: in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_modes();
    logic [1:0]  v_mode[9]  = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd0};
    logic [7:0]  v_coeff[9] = '{8'h00, 8'h09, 8'h09, 8'h09, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [31:0] v_in[9]    = '{32'h21343612, 32'h00000000, 32'h00FAF700, 32'h77F60000,
                                32'h00101F40, 32'h00204060, 32'h55FFFFFF, 32'hAB123456,
                                32'h00FFFF00};
    logic [31:0] v_exp[9]   = '{32'hFF213512, 32'hFF090909, 32'hFFFFFF09, 32'hFFFF0909,
                                32'hFF000020, 32'hFF404040, 32'hFFFFFFFF, 32'hFF123456,
                                32'hFF00FF00};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      filter_mode = v_mode[i]; coeff = v_coeff[i]; in_data = v_in[i];
      in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; filter_mode = 2'd3; coeff = 8'hFF;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || result !== v_exp[i]) begin
        n_fail++;
        $display("FAIL mode_vec%0d: out_valid=%b result=%h, want 1 %h",
                 i, out_valid, result, v_exp[i]);
      end
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL drained: out_valid=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    out_ready = 1'b1;
    filter_mode = 2'd0; coeff = 8'h00; in_data = 32'h21343612; in_valid = 1'b1;
    @(negedge clk);
    filter_mode = 2'd1; coeff = 8'h09; in_data = 32'h00FAF700; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || result !== 32'hFF213512) begin
      n_fail++;
      $display("FAIL switch_first: out_valid=%b result=%h, want 1 ff213512", out_valid, result);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || result !== 32'hFFFFFF09) begin
      n_fail++;
      $display("FAIL switch_second: out_valid=%b result=%h, want 1 ffffff09", out_valid, result);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL switch_drain: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_stall();
    logic [31:0] pix[4] = '{32'h10203040, 32'h01FFFF02, 32'hAA0001BB, 32'h00FE0133};
    logic [31:0] want;
    logic [31:0] held;
    int sent = 0;
    int got  = 0;
    exp_q = '{32'hFF102840, 32'hFF01FF02, 32'hFFAA00BB, 32'hFF007F33};
    filter_mode = 2'd0; coeff = 8'h00;
    held = '0;
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 2 && cyc <= 4);
      in_valid  = (sent < 4);
      in_data   = (sent < 4) ? pix[sent] : 32'h0;
      #1;
      if (cyc >= 2 && cyc <= 4) begin
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL stall_full c%0d: in_ready=%b out_valid=%b, want 0 1",
                   cyc, in_ready, out_valid);
        end
      end
      if (cyc == 2) held = result;
      if (cyc == 3 || cyc == 4) begin
        n_checks++;
        if (result !== held) begin
          n_fail++;
          $display("FAIL stall_hold c%0d: result=%h want %h", cyc, result, held);
        end
      end
      if (out_valid && out_ready) begin
        want = exp_q.pop_front();
        got++;
        n_checks++;
        if (result !== want) begin
          n_fail++;
          $display("FAIL stall_out%0d: result=%h want %h", got, result, want);
        end
      end
      if (in_valid && in_ready) sent++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (got != 4 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL stall_count: got %0d outputs, want 4", got);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_idle: busy=%b out_valid=%b want 0 0", busy, out_valid);
    end
  endtask

  task automatic test_mid_reset();
    int stale = 0;
    @(negedge clk);
    out_ready = 1'b0; filter_mode = 2'd1; coeff = 8'h05;
    in_data = 32'h00111111; in_valid = 1'b1;
    @(negedge clk);
    in_data = 32'h00222222;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL pre_reset_full: busy=%b out_valid=%b in_ready=%b want 1 1 0",
               busy, out_valid, in_ready);
    end
    n_rst = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || result !== 32'h0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: out_valid=%b busy=%b result=%h in_ready=%b, want 0 0 00000000 1",
               out_valid, busy, result, in_ready);
    end
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) stale++;
    end
    n_checks++;
    if (stale != 0) begin
      n_fail++;
      $display("FAIL no_stale: %0d cycles with stale output, want 0", stale);
    end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_back_to_back();
    test_stall();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_filter_pipe.md
PIXEL_FILTER_PIPE -- requirements
Module: pixel_filter_pipe

Interface
REQ-001 SHALL have parameter CH_W, default 8, meaning bits per colour channel (legal range 4..16).
REQ-002 SHALL have parameter ALPHA, default all-ones of CH_W, meaning the constant written to the output alpha channel.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state on its rising edge.
REQ-004 SHALL have port n_rst  input  1  meaning the reset, asynchronous and active-low.
REQ-005 SHALL have port in  input  4*CH_W  meaning the input word {c3,c2,c1,c0}, c3 in the MSBs.
REQ-006 SHALL have port in_valid  input  1  meaning `in` carries a pixel.
REQ-007 SHALL have port in_ready  output  1  meaning the block accepts a pixel this cycle.
REQ-008 SHALL have port filterMode  input  2  meaning the operation, sampled with the pixel.
REQ-009 SHALL have port brightnessCoeff  input  CH_W  meaning the brightness offset, sampled with the pixel.
REQ-010 SHALL have port result  output  4*CH_W  meaning the output word {alpha,R,G,B}.
REQ-011 SHALL have port out_valid  output  1  meaning `result` holds a processed pixel.
REQ-012 SHALL have port out_ready  input  1  meaning the consumer takes `result` this cycle.
REQ-013 SHALL have port busy  output  1  meaning at least one pipeline stage is occupied.

Function
REQ-014 SHALL transfer a pixel on any rising edge where in_valid and in_ready are both 1, and SHALL capture filterMode and brightnessCoeff on that same edge.
REQ-015 SHALL consume an output on any rising edge where out_valid and out_ready are both 1.
REQ-016 SHALL use two register stages: S1 holds the captured operands, and S2 holds the computed result.
REQ-017 SHALL have a latency of 2: a pixel accepted at edge N drives out_valid=1 from edge N+1 onward until it is consumed.
REQ-018 SHALL give each stage a valid bit; a stage advances when it is empty or its successor advances; in_ready = !S1v | !S2v | out_ready.
REQ-019 SHALL sustain one pixel per cycle when out_ready is held at 1.
REQ-020 SHALL hold result, out_valid and S1 contents unchanged while out_valid=1 and out_ready=0.
REQ-021 SHALL lose and duplicate no pixel under any valid/ready pattern.
REQ-022 SHALL implement mode 00 (debayer), with input {R,G1,G2,B}: result = {ALPHA, R, (G1+G2)>>1, B}; the sum is formed at CH_W+1 bits and truncated.
REQ-023 SHALL implement mode 01 (brighten), with input {x,R,G,B}: each of R, G, B = min(c + brightnessCoeff, 2^CH_W-1); result = {ALPHA, ...}.
REQ-024 SHALL implement mode 10 (darken): each of R, G, B = max(c - brightnessCoeff, 0); alpha = ALPHA.
REQ-025 SHALL implement mode 11 (grayscale): Y = (R + 2G + B) >> 2, formed at CH_W+2 bits; result = {ALPHA, Y, Y, Y}.
REQ-026 SHALL ignore input c3 in modes 01, 10 and 11.
REQ-027 SHALL let filterMode or brightnessCoeff changes affect only pixels accepted afterwards, never pixels already in flight.
REQ-028 SHALL hold S1 unchanged when in_valid=1 but in_ready=0.
REQ-029 SHALL drive busy = S1v | S2v.

Reset
REQ-030 SHALL, on n_rst=0, immediately clear S1v and S2v and drive out_valid=0, busy=0 and result=0, regardless of clk.
REQ-031 SHALL drive in_ready=1 during reset and in the first cycle after deassertion.
REQ-032 SHALL discard any in-flight pixels on a reset mid-stream and never emit them after reset is released.

Verification
REQ-033 SHALL pass this test: mode 00, in=0x21343612, out_ready=1 -> two edges later result=0xFF213512, out_valid=1.
REQ-034 SHALL pass this test: mode 01, coeff 0x09, in=0x00000000 then 0x00FAF700 -> results 0xFF090909 then 0xFFFFFF09.
REQ-035 SHALL pass this test: mode 10, coeff 0x20, in=0x00101F40 -> result 0xFF000020; mode 11, in=0x00204060 -> 0xFF404040.
REQ-036 SHALL pass this test: a stream of 4 pixels with out_ready=0 for 3 cycles mid-stream -> result held stable, in_ready=0 once both stages are full, all 4 outputs in order with none lost.
REQ-037 SHALL pass this test: mode switched from 00 to 01 on the cycle after a pixel is accepted -> that pixel is still debayered, and the next is brightened.
REQ-038 SHALL pass this test: n_rst pulsed low with 2 pixels in flight -> out_valid=0 and busy=0 immediately, and no stale output after release.
